// File: rtl/mc_controller_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The controller is the master: it reads instr/zero and drives every enable and select.
interface mc_controller_if;
  logic [31:0] instr;
  logic        zero;
  logic [2:0]  state;
  logic        pcWE;
  logic        irWE;
  logic        grfWE;
  logic        dmWE;
  logic [1:0]  npcSel;
  logic [1:0]  grfSlt;
  logic [1:0]  toReg;
  logic [1:0]  extOp;
  logic [1:0]  aluOp;
  logic        aluB;
  logic [31:0] instrCnt;

  modport master (
    input  instr, zero,
    output state, pcWE, irWE, grfWE, dmWE, npcSel, grfSlt, toReg,
           extOp, aluOp, aluB, instrCnt
  );

  modport slave (
    output instr, zero,
    input  state, pcWE, irWE, grfWE, dmWE, npcSel, grfSlt, toReg,
           extOp, aluOp, aluB, instrCnt
  );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset controller: IF/DCD/EXE/MEM/WB FSM with combinational
// control decode from the current state and the held instruction word.
module mc_controller (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master ctrl
);
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DCD = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_JR, I_UNK
  } instr_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q;
  instr_e      kind;
  logic        retire;
  logic        pc_we, ir_we, grf_we, dm_we;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^ctrl.instr[25:6];

  always_comb begin
    kind = I_UNK;
    case (ctrl.instr[31:26])
      6'b000000: begin
        case (ctrl.instr[5:0])
          6'b100001: kind = I_ADDU;
          6'b100011: kind = I_SUBU;
          6'b001000: kind = I_JR;
          default:   kind = I_UNK;
        endcase
      end
      6'b001101: kind = I_ORI;
      6'b100011: kind = I_LW;
      6'b101011: kind = I_SW;
      6'b000100: kind = I_BEQ;
      6'b001111: kind = I_LUI;
      6'b000011: kind = I_JAL;
      default:   kind = I_UNK;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = S_IF;
    retire       = 1'b0;
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    grf_we       = 1'b0;
    dm_we        = 1'b0;
    ctrl.npcSel  = 2'd0;
    ctrl.grfSlt  = 2'd0;
    ctrl.toReg   = 2'd0;
    ctrl.extOp   = 2'd0;
    ctrl.aluOp   = 2'd0;
    ctrl.aluB    = 1'b0;

    // ALU setup is held from EXE through WB so the DM address and result stay stable.
    if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
      case (kind)
        I_BEQ:        begin ctrl.aluOp = 2'd1; ctrl.extOp = 2'd2; end
        I_LW, I_SW:   ctrl.aluB = 1'b1;
        I_SUBU:       ctrl.aluOp = 2'd1;
        I_ORI:        begin ctrl.aluOp = 2'd3; ctrl.aluB = 1'b1; ctrl.extOp = 2'd1; end
        I_LUI:        begin ctrl.aluB = 1'b1; ctrl.extOp = 2'd3; end
        default:      ;
      endcase
    end

    case (state_q)
      S_IF: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_DCD;
      end
      S_DCD: begin
        case (kind)
          I_JAL: begin
            grf_we      = 1'b1;
            ctrl.grfSlt = 2'd2;
            ctrl.toReg  = 2'd2;
            pc_we       = 1'b1;
            ctrl.npcSel = 2'd2;
            retire      = 1'b1;
          end
          I_JR: begin
            pc_we       = 1'b1;
            ctrl.npcSel = 2'd3;
            retire      = 1'b1;
          end
          I_UNK:   retire  = 1'b1;
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        case (kind)
          I_BEQ: begin
            ctrl.npcSel = 2'd1;
            pc_we       = ctrl.zero;
            retire      = 1'b1;
          end
          I_LW, I_SW:                    state_d = S_MEM;
          I_ADDU, I_SUBU, I_ORI, I_LUI:  state_d = S_WB;
          default:                       state_d = S_IF;
        endcase
      end
      S_MEM: begin
        case (kind)
          I_SW: begin
            dm_we  = 1'b1;
            retire = 1'b1;
          end
          I_LW:    state_d = S_WB;
          default: state_d = S_IF;
        endcase
      end
      S_WB: begin
        grf_we      = 1'b1;
        retire      = 1'b1;
        ctrl.grfSlt = (kind == I_ADDU || kind == I_SUBU) ? 2'd1 : 2'd0;
        ctrl.toReg  = (kind == I_LW) ? 2'd1 : 2'd0;
      end
      default: state_d = S_IF;
    endcase
  end

  // Enables are gated by reset so they drop the instant reset asserts.
  assign ctrl.pcWE     = pc_we  & reset;
  assign ctrl.irWE     = ir_we  & reset;
  assign ctrl.grfWE    = grf_we & reset;
  assign ctrl.dmWE     = dm_we  & reset;
  assign ctrl.state    = state_q;
  assign ctrl.instrCnt = cnt_q;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + 32'd1;
    end
  end
endmodule
